// File: rtl/sirv_rtc_alarm_sched_if.sv
// Slot write / acknowledge bus for the RTC alarm scheduler.
// Master drives slot updates and acks; slave is the scheduler.
interface sirv_rtc_alarm_sched_if #(
    parameter int IDX_W = 2
);
    logic             wr_valid;
    logic [IDX_W-1:0] wr_idx;
    logic             wr_arm;
    logic [31:0]      wr_deadline;
    logic [31:0]      wr_period;
    logic             ack_valid;
    logic [IDX_W-1:0] ack_idx;

    modport master (
        output wr_valid,
        output wr_idx,
        output wr_arm,
        output wr_deadline,
        output wr_period,
        output ack_valid,
        output ack_idx
    );

    modport slave (
        input wr_valid,
        input wr_idx,
        input wr_arm,
        input wr_deadline,
        input wr_period,
        input ack_valid,
        input ack_idx
    );
endinterface

// File: rtl/sirv_rtc_alarm_sched.sv
// Multiplexes software alarm slots onto the single RTC comparator.
// Periodic reload is enabled by defining SIRV_RTC_SCHED_PERIODIC_EN.
module sirv_rtc_alarm_sched #(
    parameter int IDX_W = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    sirv_rtc_alarm_sched_if.slave   bus,
    input  logic [31:0]             rtc_s,
    input  logic                    rtc_ip,
    output logic                    rtc_cmp_wr_valid,
    output logic [31:0]             rtc_cmp_wr_bits,
    output logic [(1<<IDX_W)-1:0]   armed,
    output logic [(1<<IDX_W)-1:0]   pending,
    output logic                    irq,
    output logic                    busy
);
    localparam int NSLOT = 1 << IDX_W;
    localparam logic [IDX_W-1:0] LAST = '1;

    typedef enum logic [2:0] {
        S_SCAN,
        S_PROG,
        S_SETTLE,
        S_WAIT,
        S_FIRE
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      min_q, min_d;
    logic             settle_q, settle_d;
    logic             dirty_q;
    logic             irq_q;
    logic             scan_start;
    logic             fire;

    logic [31:0]      deadline_q [NSLOT];
    logic [NSLOT-1:0] armed_q;
    logic [NSLOT-1:0] pending_q;

    logic [NSLOT-1:0] wr_hit;
    logic [NSLOT-1:0] ack_hit;
    logic [NSLOT-1:0] due;
    logic [NSLOT-1:0] set_pend;

`ifdef SIRV_RTC_SCHED_PERIODIC_EN
    logic [31:0]      period_q [NSLOT];
`else
    logic             unused_period;
    assign unused_period = ^bus.wr_period;
`endif

    // Per-slot decode of writes, acks and expiry against the RTC count.
    always_comb begin
        wr_hit   = '0;
        ack_hit  = '0;
        due      = '0;
        set_pend = '0;
        for (int i = 0; i < NSLOT; i++) begin
            wr_hit[i]   = bus.wr_valid && (bus.wr_idx == IDX_W'(i));
            ack_hit[i]  = bus.ack_valid && (bus.ack_idx == IDX_W'(i));
            due[i]      = armed_q[i] && (deadline_q[i] <= rtc_s);
            set_pend[i] = fire && due[i] && !wr_hit[i];
        end
    end

    // Scheduler next-state: scan, program, settle, wait, fire.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        min_d      = min_q;
        settle_d   = settle_q;
        scan_start = 1'b0;
        fire       = 1'b0;
        unique case (state_q)
            S_SCAN: begin
                if (bus.wr_valid) begin
                    idx_d      = '0;
                    min_d      = '1;
                    scan_start = 1'b1;
                end else begin
                    if (armed_q[idx_q] && (deadline_q[idx_q] < min_q)) begin
                        min_d = deadline_q[idx_q];
                    end
                    idx_d = idx_q + 1'b1;
                    if (idx_q == LAST) begin
                        state_d = S_PROG;
                    end
                end
            end
            S_PROG: begin
                settle_d = 1'b0;
                state_d  = S_SETTLE;
            end
            S_SETTLE: begin
                if (settle_q) begin
                    state_d = S_WAIT;
                end else begin
                    settle_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (dirty_q) begin
                    state_d    = S_SCAN;
                    idx_d      = '0;
                    min_d      = '1;
                    scan_start = 1'b1;
                end else if (rtc_ip) begin
                    state_d = S_FIRE;
                end
            end
            S_FIRE: begin
                fire       = 1'b1;
                state_d    = S_SCAN;
                idx_d      = '0;
                min_d      = '1;
                scan_start = 1'b1;
            end
            default: begin
                state_d    = S_SCAN;
                idx_d      = '0;
                min_d      = '1;
                scan_start = 1'b1;
            end
        endcase
    end

    // Scheduler state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_SCAN;
            idx_q    <= '0;
            min_q    <= '1;
            settle_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            min_q    <= min_d;
            settle_q <= settle_d;
        end
    end

    // A table change outside a scan forces a rescan from WAIT.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dirty_q <= 1'b0;
        end else if (scan_start) begin
            dirty_q <= 1'b0;
        end else if (bus.wr_valid) begin
            dirty_q <= 1'b1;
        end
    end

    // Slot table: software writes win over expiry in the same cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            armed_q <= '0;
            for (int i = 0; i < NSLOT; i++) begin
                deadline_q[i] <= '0;
`ifdef SIRV_RTC_SCHED_PERIODIC_EN
                period_q[i]   <= '0;
`endif
            end
        end else begin
            for (int i = 0; i < NSLOT; i++) begin
                if (wr_hit[i]) begin
                    armed_q[i]    <= bus.wr_arm;
                    deadline_q[i] <= bus.wr_deadline;
`ifdef SIRV_RTC_SCHED_PERIODIC_EN
                    if (bus.wr_arm) begin
                        period_q[i] <= bus.wr_period;
                    end
`endif
                end else if (fire && due[i]) begin
`ifdef SIRV_RTC_SCHED_PERIODIC_EN
                    if (period_q[i] != 32'd0) begin
                        deadline_q[i] <= deadline_q[i] + period_q[i];
                    end else begin
                        armed_q[i] <= 1'b0;
                    end
`else
                    armed_q[i] <= 1'b0;
`endif
                end
            end
        end
    end

    // Pending flags: expiry beats a same-cycle ack.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending_q <= '0;
        end else begin
            for (int i = 0; i < NSLOT; i++) begin
                if (set_pend[i]) begin
                    pending_q[i] <= 1'b1;
                end else if (ack_hit[i]) begin
                    pending_q[i] <= 1'b0;
                end
            end
        end
    end

    // Interrupt line follows the pending set one cycle later.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |pending_q;
        end
    end

    assign rtc_cmp_wr_valid = (state_q == S_PROG);
    assign rtc_cmp_wr_bits  = min_q;
    assign armed            = armed_q;
    assign pending          = pending_q;
    assign irq              = irq_q;
    assign busy             = (state_q != S_WAIT);

endmodule
